ldmx_dma_ob_cmd: RTL and testbench
==================================

# ldmx_dma_ob_cmd

Host-to-firmware command engine on the outbound DMA stream. Consumes 64-bit AXI-Stream frames sent by software on DMA0 outbound and turns each beat into a register write or read on the internal strobe/ack register bus. This bus is the same wstr/wack, rstr/rack style used by the fast-control, GT, wishbone-bridge and DAQ register blocks. It is the outbound counterpart of the DAQ event path, which writes the inbound stream. It reports read results, frame/command/error counts and a busy flag.

## Interface
Parameters:
- ADDR_W, 18, word-address width on the register bus (byte address bits [19:2])
- ACK_TIMEOUT, 255, cycles a strobe may stay high without ack before abort (1..65535)
- CNT_W, 16, width of the status counters

Ports:
- axilClk  in  1  single clock; the stream is already crossed into this domain upstream
- axilRst  in  1  synchronous, active-high reset
- dmaObMaster_tValid  in  1  stream beat valid
- dmaObMaster_tData  in  64  beat: [63:60] opcode, [59:50] reserved, [49:32] word address, [31:0] data
- dmaObMaster_tKeep  in  8  byte enables; must be 8'hFF
- dmaObMaster_tLast  in  1  last beat of frame
- dmaObSlave_tReady  out  1  beat accept
- cmd_addr  out  ADDR_W  register word address, held for the whole access
- cmd_wdata  out  32  write data, held for the whole access
- cmd_wstr  out  1  write strobe, level, held until ack or timeout
- cmd_wack  in  1  write acknowledge
- cmd_rstr  out  1  read strobe, level, held until ack or timeout
- cmd_rack  in  1  read acknowledge
- cmd_rdata  in  32  read data, valid with cmd_rack
- rd_data  out  32  last read result
- rd_valid  out  1  one-cycle pulse when rd_data updates
- frame_count  out  CNT_W  frames completed (tLast accepted), saturating
- cmd_count  out  CNT_W  accesses acknowledged, saturating
- err_count  out  CNT_W  errors (bad opcode, bad tKeep, timeout), saturating
- busy  out  1  high whenever state ≠ IDLE

## Operation
- Opcodes: 4'h1 = write, 4'h2 = read, all others illegal. Reserved bits are ignored.
- States:
  - IDLE: tReady=1. On an accepted beat:
    - legal write → WRITE
    - legal read → READ
    - illegal opcode or tKeep≠8'hFF → err_count+1; next state is IDLE if tLast, otherwise DRAIN
  - WRITE: cmd_wstr=1.
    - On cmd_wack: cmd_count+1, return to IDLE.
    - If ACK_TIMEOUT cycles pass with no ack: drop the strobe, err_count+1, go to DRAIN, unless the command beat was tLast, in which case go to IDLE.
  - READ: cmd_rstr=1.
    - On cmd_rack: capture cmd_rdata into rd_data, pulse rd_valid, cmd_count+1, return to IDLE.
    - Timeout handling is the same as WRITE.
  - DRAIN: tReady=1. Discards beats until tLast is accepted, then goes to IDLE.
- frame_count increments whenever tLast is accepted (IDLE or DRAIN), or when a tLast command beat completes or times out. Each frame counts exactly once.
- Each beat is latched at acceptance. cmd_addr and cmd_wdata are stable from strobe rise until strobe fall.
- All counters saturate at all-ones and never wrap.
- Only one access is outstanding at a time. The engine never raises wstr and rstr together.
- Reset values: tReady=0 during reset, then 1 in IDLE. Strobes 0, rd_data 0, rd_valid 0, all counters 0, busy 0.
- Reset asserted mid-access drops the strobe on the next edge with no count update. Any partial frame is lost; upstream is flushed by the same reset.

## Timing
- A beat accepted on edge N puts the strobe high from N+1.
- An ack sampled high on edge M brings the strobe low and tReady high from M+1. rd_data and rd_valid are updated from M+1.
- Minimum command throughput is one beat per 2 cycles: an ack in the first strobe cycle gives accept, strobe, accept.
- The timeout counter starts at the strobe-rise edge. The strobe falls after exactly ACK_TIMEOUT cycles high.
- An ack arriving in the same cycle as the timeout expiry wins: the access counts as a success.
- An ack while no strobe is high is ignored.
- Counter updates are visible one cycle after the causing edge.

## Test plan
- Single-beat frame: write, addr 18'h00104, data 32'hDEADBEEF, tLast. Required: cmd_wstr high 1 cycle after accept with addr/data stable; wack after 3 cycles; strobe drops next cycle; cmd_count=1, frame_count=1, err_count=0.
- 3-beat frame (write, read, write) with immediate acks and cmd_rdata=32'h12345678. Required: rd_valid pulses once with rd_data=32'h12345678; cmd_count=3, frame_count=1; beats accepted every 2 cycles.
- Illegal opcode 4'h7 in beat 1 of a 4-beat frame. Required: no strobe ever rises; beats 2–4 drained; err_count=1, frame_count=1, cmd_count=0; next frame executes normally.
- Timeout with ACK_TIMEOUT=8: read never acked on beat 1 of a 2-beat frame. Required: rstr high exactly 8 cycles; err_count=1; beat 2 drained; frame_count=1. Repeat with the ack landing on the 8th cycle: success, err_count unchanged.
- tKeep=8'h0F on a tLast write. Required: err_count+1, no strobe, frame_count+1, back to IDLE.
- Reset asserted 2 cycles into a held write strobe. Required: strobe 0, busy 0, all counters 0 on the next edge; tReady=1 one cycle after reset deasserts.

Source files
------------

// File: rtl/ldmx_dma_ob_cmd.sv
// Outbound DMA command engine: turns 64-bit stream beats into strobe/ack
// register writes and reads, and keeps read-back and frame/command/error status.
module ldmx_dma_ob_cmd #(
    parameter int unsigned ADDR_W      = 18,
    parameter int unsigned ACK_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              axilClk,
    input  logic              axilRst,
    input  logic              dmaObMaster_tValid,
    input  logic [63:0]       dmaObMaster_tData,
    input  logic [7:0]        dmaObMaster_tKeep,
    input  logic              dmaObMaster_tLast,
    output logic              dmaObSlave_tReady,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [31:0]       cmd_wdata,
    output logic              cmd_wstr,
    input  logic              cmd_wack,
    output logic              cmd_rstr,
    input  logic              cmd_rack,
    input  logic [31:0]       cmd_rdata,
    output logic [31:0]       rd_data,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  frame_count,
    output logic [CNT_W-1:0]  cmd_count,
    output logic [CNT_W-1:0]  err_count,
    output logic              busy
);

    localparam int unsigned TMO_W = 16;
    localparam logic [3:0]  OP_WR = 4'h1;
    localparam logic [3:0]  OP_RD = 4'h2;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN
    } state_t;

    state_t             state;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               beat_last;

    logic               accept;
    logic [3:0]         opcode;
    logic               keep_ok;
    logic               tmo_hit;
    logic               ack;
    logic               unused_bits;

    // Saturating increment shared by all status counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign accept      = dmaObMaster_tValid && dmaObSlave_tReady;
    assign opcode      = dmaObMaster_tData[63:60];
    assign keep_ok     = (dmaObMaster_tKeep == 8'hFF);
    assign tmo_hit     = (tmo_cnt == TMO_W'(ACK_TIMEOUT - 1));
    assign ack         = (state == WRITE) ? cmd_wack : cmd_rack;
    assign unused_bits = ^dmaObMaster_tData[59:50];

    // Command FSM with registered strobes, handshake and status counters.
    always_ff @(posedge axilClk) begin
        if (axilRst) begin
            state             <= IDLE;
            tmo_cnt           <= '0;
            beat_last         <= 1'b0;
            dmaObSlave_tReady <= 1'b0;
            cmd_addr          <= '0;
            cmd_wdata         <= '0;
            cmd_wstr          <= 1'b0;
            cmd_rstr          <= 1'b0;
            rd_data           <= '0;
            rd_valid          <= 1'b0;
            frame_count       <= '0;
            cmd_count         <= '0;
            err_count         <= '0;
            busy              <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    dmaObSlave_tReady <= 1'b1;
                    if (accept) begin
                        cmd_addr  <= ADDR_W'(dmaObMaster_tData[49:32]);
                        cmd_wdata <= dmaObMaster_tData[31:0];
                        beat_last <= dmaObMaster_tLast;
                        tmo_cnt   <= '0;
                        if (keep_ok && opcode == OP_WR) begin
                            state             <= WRITE;
                            cmd_wstr          <= 1'b1;
                            dmaObSlave_tReady <= 1'b0;
                            busy              <= 1'b1;
                        end else if (keep_ok && opcode == OP_RD) begin
                            state             <= READ;
                            cmd_rstr          <= 1'b1;
                            dmaObSlave_tReady <= 1'b0;
                            busy              <= 1'b1;
                        end else begin
                            err_count <= sat_inc(err_count);
                            if (dmaObMaster_tLast) begin
                                frame_count <= sat_inc(frame_count);
                            end else begin
                                state <= DRAIN;
                                busy  <= 1'b1;
                            end
                        end
                    end
                end
                WRITE, READ: begin
                    if (ack) begin
                        // Ack wins even on the expiry cycle.
                        cmd_wstr          <= 1'b0;
                        cmd_rstr          <= 1'b0;
                        cmd_count         <= sat_inc(cmd_count);
                        state             <= IDLE;
                        dmaObSlave_tReady <= 1'b1;
                        busy              <= 1'b0;
                        if (state == READ) begin
                            rd_data  <= cmd_rdata;
                            rd_valid <= 1'b1;
                        end
                        if (beat_last) begin
                            frame_count <= sat_inc(frame_count);
                        end
                    end else if (tmo_hit) begin
                        cmd_wstr          <= 1'b0;
                        cmd_rstr          <= 1'b0;
                        err_count         <= sat_inc(err_count);
                        dmaObSlave_tReady <= 1'b1;
                        if (beat_last) begin
                            frame_count <= sat_inc(frame_count);
                            state       <= IDLE;
                            busy        <= 1'b0;
                        end else begin
                            state <= DRAIN;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                DRAIN: begin
                    dmaObSlave_tReady <= 1'b1;
                    if (accept && dmaObMaster_tLast) begin
                        frame_count <= sat_inc(frame_count);
                        state       <= IDLE;
                        busy        <= 1'b0;
                    end
                end
                default: begin
                    state             <= IDLE;
                    dmaObSlave_tReady <= 1'b1;
                    cmd_wstr          <= 1'b0;
                    cmd_rstr          <= 1'b0;
                    busy              <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ldmx_dma_ob_cmd.sv
// Scoreboard bench for the outbound DMA command engine.
module tb_ldmx_dma_ob_cmd;

    localparam int unsigned TMO = 8;

    typedef struct {
        logic        rd;
        logic [17:0] addr;
        logic [31:0] wdata;
        int          hi;
    } exp_t;

    logic        axilClk = 1'b0;
    logic        axilRst = 1'b1;
    logic        tvalid = 1'b0;
    logic [63:0] tdata = '0;
    logic [7:0]  tkeep = 8'hFF;
    logic        tlast = 1'b0;
    logic        tready;
    logic [17:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        cmd_wstr;
    logic        cmd_wack = 1'b0;
    logic        cmd_rstr;
    logic        cmd_rack = 1'b0;
    logic [31:0] cmd_rdata = '0;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [15:0] frame_count;
    logic [15:0] cmd_count;
    logic [15:0] err_count;
    logic        busy;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          ack_at = 0;
    logic [31:0] rd_val = '0;
    exp_t        sb_q[$];
    logic [31:0] rd_q[$];
    int          acc_t[$];

    int          ncyc = 0;
    bit          in_acc = 0;
    int          hi_cnt = 0;
    bit          stable_ok = 1;
    bit          prev_acc = 0;
    exp_t        cur;

    ldmx_dma_ob_cmd #(.ADDR_W(18), .ACK_TIMEOUT(TMO), .CNT_W(16)) dut (
        .axilClk(axilClk),
        .axilRst(axilRst),
        .dmaObMaster_tValid(tvalid),
        .dmaObMaster_tData(tdata),
        .dmaObMaster_tKeep(tkeep),
        .dmaObMaster_tLast(tlast),
        .dmaObSlave_tReady(tready),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .cmd_wstr(cmd_wstr),
        .cmd_wack(cmd_wack),
        .cmd_rstr(cmd_rstr),
        .cmd_rack(cmd_rack),
        .cmd_rdata(cmd_rdata),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .frame_count(frame_count),
        .cmd_count(cmd_count),
        .err_count(err_count),
        .busy(busy)
    );

    always #5 axilClk = ~axilClk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Responder and monitor: acks strobes on the configured cycle, pops the scoreboard.
    always @(negedge axilClk) begin
        ncyc++;
        if (axilRst) begin
            in_acc   = 0;
            hi_cnt   = 0;
            prev_acc = 0;
            cmd_wack = 1'b0;
            cmd_rack = 1'b0;
        end else begin
            if (cmd_wstr && cmd_rstr) check("dual_strobe", 1, 0);
            if ((cmd_wstr || cmd_rstr) && !in_acc) begin
                in_acc    = 1;
                stable_ok = 1;
                check("rise_after_accept", 64'(prev_acc), 1);
                if (sb_q.size() == 0) begin
                    check("unexpected_strobe", 1, 0);
                    cur = '{rd: 1'b0, addr: '0, wdata: '0, hi: 0};
                end else begin
                    cur = sb_q.pop_front();
                end
                check("acc_type_rd", 64'(cmd_rstr), 64'(cur.rd));
                check("acc_addr", 64'(cmd_addr), 64'(cur.addr));
                if (!cur.rd) check("acc_wdata", 64'(cmd_wdata), 64'(cur.wdata));
            end
            if (cmd_wstr || cmd_rstr) begin
                hi_cnt++;
                if (cmd_addr != cur.addr || (!cur.rd && cmd_wdata != cur.wdata)) stable_ok = 0;
            end else if (in_acc) begin
                check("strobe_cycles", 64'(hi_cnt), 64'(cur.hi));
                check("addr_data_stable", 64'(stable_ok), 1);
                in_acc = 0;
                hi_cnt = 0;
            end
            cmd_wack  = cmd_wstr && ack_at != 0 && hi_cnt == ack_at;
            cmd_rack  = cmd_rstr && ack_at != 0 && hi_cnt == ack_at;
            cmd_rdata = rd_val;
            if (rd_valid) begin
                if (rd_q.size() == 0) check("unexpected_rd_valid", 1, 0);
                else check("rd_data", 64'(rd_data), 64'(rd_q.pop_front()));
            end
            prev_acc = tvalid && tready;
            if (prev_acc) acc_t.push_back(ncyc);
        end
    end

    // Drive one beat starting just after a posedge; returns just after the accepting posedge.
    task automatic send_beat(input logic [3:0] op, input logic [17:0] a, input logic [31:0] d,
                             input logic [7:0] keep, input logic last, input bit exec);
        logic [63:0] w;
        bit ok;
        bit done;
        exp_t e;
        w = '0;
        w[63:60] = op;
        w[59:50] = 10'h3A5;
        w[49:32] = a;
        w[31:0]  = d;
        if (exec) begin
            e.rd    = (op == 4'h2);
            e.addr  = a;
            e.wdata = d;
            e.hi    = (ack_at == 0) ? int'(TMO) : ack_at;
            sb_q.push_back(e);
            if (e.rd && ack_at != 0) rd_q.push_back(rd_val);
        end
        tvalid = 1'b1;
        tdata  = w;
        tkeep  = keep;
        tlast  = last;
        done   = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge axilClk);
            ok = tready;
            @(posedge axilClk);
            if (ok) done = 1;
        end
        if (!done) check("beat_accept_timeout", 0, 1);
        #1;
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic wait_idle_and_check(input int ec, input int ef, input int ee);
        bit done;
        done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge axilClk);
            if (!busy && tready && !cmd_wstr && !cmd_rstr) done = 1;
        end
        if (!done) check("idle_timeout", 0, 1);
        check("cmd_count", 64'(cmd_count), 64'(ec));
        check("frame_count", 64'(frame_count), 64'(ef));
        check("err_count", 64'(err_count), 64'(ee));
        @(posedge axilClk);
        #1;
    endtask

    initial begin
        // Reset values
        repeat (2) @(posedge axilClk);
        @(negedge axilClk);
        check("rst_tready", 64'(tready), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_strobes", 64'({cmd_wstr, cmd_rstr}), 0);
        check("rst_rd", 64'({rd_valid, rd_data}), 0);
        check("rst_counts", 64'({frame_count, cmd_count, err_count}), 0);
        @(posedge axilClk);
        #1 axilRst = 1'b0;
        @(posedge axilClk);
        #1;

        // Single-beat write, ack on third strobe cycle
        ack_at = 3;
        send_beat(4'h1, 18'h00104, 32'hDEADBEEF, 8'hFF, 1'b1, 1);
        wait_idle_and_check(1, 1, 0);

        // Write/read/write frame with immediate acks; accepts every 2 cycles
        ack_at = 1;
        rd_val = 32'h12345678;
        acc_t.delete();
        send_beat(4'h1, 18'h00010, 32'h0000_0011, 8'hFF, 1'b0, 1);
        send_beat(4'h2, 18'h00020, 32'h0000_0000, 8'hFF, 1'b0, 1);
        send_beat(4'h1, 18'h3FFFF, 32'hFFFF_0000, 8'hFF, 1'b1, 1);
        wait_idle_and_check(4, 2, 0);
        check("accepts_seen", 64'(acc_t.size()), 3);
        if (acc_t.size() == 3) begin
            check("accept_gap1", 64'(acc_t[1] - acc_t[0]), 2);
            check("accept_gap2", 64'(acc_t[2] - acc_t[1]), 2);
        end

        // Illegal opcode on beat 1 of 4, remaining beats drained, then a normal frame
        send_beat(4'h7, 18'h00001, 32'h1, 8'hFF, 1'b0, 0);
        send_beat(4'h1, 18'h00002, 32'h2, 8'hFF, 1'b0, 0);
        send_beat(4'h2, 18'h00003, 32'h3, 8'hFF, 1'b0, 0);
        send_beat(4'h1, 18'h00004, 32'h4, 8'hFF, 1'b1, 0);
        wait_idle_and_check(4, 3, 1);
        ack_at = 2;
        rd_val = 32'hA5A5_5A5A;
        send_beat(4'h2, 18'h00200, 32'h0, 8'hFF, 1'b1, 1);
        wait_idle_and_check(5, 4, 1);

        // Read never acked: times out after TMO cycles, beat 2 drained
        ack_at = 0;
        send_beat(4'h2, 18'h00300, 32'h0, 8'hFF, 1'b0, 1);
        send_beat(4'h1, 18'h00301, 32'h77, 8'hFF, 1'b1, 0);
        wait_idle_and_check(5, 5, 2);

        // Ack on the expiry cycle wins
        ack_at = int'(TMO);
        rd_val = 32'hCAFE_0001;
        send_beat(4'h2, 18'h00400, 32'h0, 8'hFF, 1'b0, 1);
        send_beat(4'h1, 18'h00401, 32'h5555_AAAA, 8'hFF, 1'b1, 1);
        wait_idle_and_check(7, 6, 2);

        // Bad tKeep on a last write
        ack_at = 1;
        send_beat(4'h1, 18'h00500, 32'h1234, 8'h0F, 1'b1, 0);
        wait_idle_and_check(7, 7, 3);

        // Reset during a held write strobe
        ack_at = 0;
        send_beat(4'h1, 18'h00600, 32'h600D_F00D, 8'hFF, 1'b1, 1);
        @(posedge axilClk);
        #1 axilRst = 1'b1;
        @(posedge axilClk);
        @(negedge axilClk);
        check("mid_rst_strobes", 64'({cmd_wstr, cmd_rstr}), 0);
        check("mid_rst_busy", 64'(busy), 0);
        check("mid_rst_counts", 64'({frame_count, cmd_count, err_count}), 0);
        check("mid_rst_rd_data", 64'(rd_data), 0);
        @(posedge axilClk);
        #1 axilRst = 1'b0;
        @(negedge axilClk);
        check("post_rst_tready_low", 64'(tready), 0);
        @(negedge axilClk);
        check("post_rst_tready_high", 64'(tready), 1);
        @(posedge axilClk);
        #1;
        ack_at = 1;
        send_beat(4'h1, 18'h00700, 32'h0BAD_CAFE, 8'hFF, 1'b1, 1);
        wait_idle_and_check(1, 1, 0);

        check("sb_left", 64'(sb_q.size()), 0);
        check("rd_left", 64'(rd_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
